// File: rtl/puf_pkg.sv
// Shared definitions for the PUF evaluation controller: default sizing and FSM states.
package puf_pkg;

  localparam int PUF_CHAL_W = 8;
  localparam int PUF_NEVAL  = 7;
  localparam int PUF_SETTLE = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_SETTLE,
    ST_SAMPLE,
    ST_REST,
    ST_DONE
  } puf_state_t;

endpackage

// File: rtl/puf_eval_ctrl_sync2.sv
// Two-flop synchronizer bringing the asynchronous arbiter result into the clk domain.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Both stages clear on reset so a stale race result never leaks into a new evaluation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/puf_eval_ctrl.sv
// Drives one challenge into the demux race chain NEVAL times and majority-votes the
// synchronized arbiter results into a response bit plus a stability flag.
module puf_eval_ctrl
  import puf_pkg::*;
#(
  parameter int CHAL_W = PUF_CHAL_W,
  parameter int NEVAL  = PUF_NEVAL,
  parameter int SETTLE = PUF_SETTLE
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [CHAL_W-1:0]            challenge,
  output logic                         launch,
  output logic [CHAL_W-1:0]            sel,
  input  logic                         arb_out,
  output logic                         busy,
  output logic                         done,
  output logic                         response,
  output logic                         stable,
  output logic [$clog2(NEVAL+1)-1:0]   ones_cnt
);

  localparam int CW = $clog2(NEVAL + 1);
  localparam int SW = $clog2(SETTLE + 1);
  localparam logic [CW-1:0] NEVAL_C     = CW'(NEVAL);
  localparam logic [CW-1:0] HALF_C      = CW'(NEVAL / 2);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);

  generate
    if ((NEVAL % 2) == 0 || NEVAL < 1 || SETTLE < 3) begin : g_bad_params
      $error("puf_eval_ctrl: NEVAL must be odd and >= 1, SETTLE must be >= 3");
    end
  endgenerate

  puf_state_t      state_q, state_d;
  logic [CW-1:0]   eval_q, eval_d;
  logic [CW-1:0]   ones_q, ones_d;
  logic [SW-1:0]   settle_q, settle_d;
  logic [CHAL_W-1:0] sel_d;
  logic            arb_sync;

  sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (arb_out),
    .q   (arb_sync)
  );

  // Sequencing: LAUNCH -> SETTLE x SETTLE -> SAMPLE -> (REST -> LAUNCH | DONE).
  always_comb begin
    state_d  = state_q;
    eval_d   = eval_q;
    ones_d   = ones_q;
    settle_d = settle_q;
    sel_d    = sel;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LAUNCH;
          sel_d   = challenge;
          eval_d  = '0;
          ones_d  = '0;
        end
      end
      ST_LAUNCH: begin
        state_d  = ST_SETTLE;
        settle_d = '0;
      end
      ST_SETTLE: begin
        if (settle_q == SETTLE_LAST) state_d = ST_SAMPLE;
        else                         settle_d = settle_q + 1'b1;
      end
      ST_SAMPLE: begin
        eval_d  = eval_q + 1'b1;
        ones_d  = ones_q + CW'(arb_sync);
        state_d = (eval_d == NEVAL_C) ? ST_DONE : ST_REST;
      end
      ST_REST:  state_d = ST_LAUNCH;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      eval_q   <= '0;
      ones_q   <= '0;
      settle_q <= '0;
      sel      <= '0;
    end else begin
      state_q  <= state_d;
      eval_q   <= eval_d;
      ones_q   <= ones_d;
      settle_q <= settle_d;
      sel      <= sel_d;
    end
  end

  // Outputs are registered from the next state; the vote uses the count including the final sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      launch   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      response <= 1'b0;
      stable   <= 1'b0;
      ones_cnt <= '0;
    end else begin
      launch <= (state_d == ST_LAUNCH);
      busy   <= (state_d != ST_IDLE);
      done   <= (state_d == ST_DONE);
      if (state_q == ST_SAMPLE && state_d == ST_DONE) begin
        response <= (ones_d > HALF_C);
        stable   <= (ones_d == '0) || (ones_d == NEVAL_C);
        ones_cnt <= ones_d;
      end
    end
  end

endmodule

// File: tb/tb_puf_eval_ctrl.sv
// Self-checking bench: a cycle-timeline model of the controller compared every cycle,
// plus directed runs with hand-computed vote results.
module tb_puf_eval_ctrl;

  localparam int NEVAL  = 7;
  localparam int SETTLE = 4;
  localparam int PER    = SETTLE + 3;
  localparam int LAST   = NEVAL * PER;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] challenge;
  logic       launch;
  logic [7:0] sel;
  logic       arb_out;
  logic       busy;
  logic       done;
  logic       response;
  logic       stable;
  logic [2:0] ones_cnt;

  int compared   = 0;
  int mismatched = 0;

  logic [NEVAL-1:0] cur_pat = '0;

  int         t;
  logic [7:0] m_sel;
  logic       m_resp;
  logic       m_stab;
  logic [2:0] m_ones;

  puf_eval_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .challenge (challenge),
    .launch    (launch),
    .sel       (sel),
    .arb_out   (arb_out),
    .busy      (busy),
    .done      (done),
    .response  (response),
    .stable    (stable),
    .ones_cnt  (ones_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Timeline model: t is the cycle number since the accepted start, -1 when idle.
  always @(posedge clk or posedge rst) begin
    int cnt;
    if (rst) begin
      t      <= -1;
      m_sel  <= '0;
      m_resp <= 1'b0;
      m_stab <= 1'b0;
      m_ones <= '0;
    end else if (t < 0) begin
      if (start) begin
        t     <= 1;
        m_sel <= challenge;
      end
    end else if (t == LAST) begin
      t <= -1;
    end else begin
      t <= t + 1;
      if (t + 1 == LAST) begin
        cnt    = $countones(cur_pat);
        m_ones <= 3'(cnt);
        m_resp <= (cnt > NEVAL / 2);
        m_stab <= (cnt == 0) || (cnt == NEVAL);
      end
    end
  end

  always @(negedge clk) begin
    checkOutput("launch",   launch,   (t >= 1 && t <= LAST - PER + 1 && (t - 1) % PER == 0));
    checkOutput("busy",     busy,     (t >= 1));
    checkOutput("done",     done,     (t == LAST));
    checkOutput("sel",      sel,      m_sel);
    checkOutput("response", response, m_resp);
    checkOutput("stable",   stable,   m_stab);
    checkOutput("ones_cnt", ones_cnt, m_ones);
  end

  task automatic applyStimulus(input logic [7:0] ch, input logic [NEVAL-1:0] pat,
                               input int rst_at, input bit extra_starts,
                               input logic exp_resp, input logic exp_stab,
                               input logic [2:0] exp_ones);
    int  n;
    bit  seen;
    @(negedge clk);
    cur_pat   = pat;
    challenge = ch;
    arb_out   = pat[0];
    start     = 1'b1;
    n    = 0;
    seen = 0;
    while (n < LAST + 10 && !seen) begin
      @(negedge clk);
      n++;
      start = 1'b0;
      if (extra_starts && (n == 5 || n == LAST)) start = 1'b1;
      if (n % PER == 0 && n / PER < NEVAL) arb_out = pat[n / PER];
      if (n == 1)  checkOutput("launch_c1", launch, 1'b1);
      if (n == 2)  checkOutput("launch_c2", launch, 1'b0);
      if (n == 43) checkOutput("launch_c43", launch, 1'b1);
      if (rst_at == n) begin
        #2 rst = 1'b1;
        #1;
        checkOutput("rst_launch",   launch,   1'b0);
        checkOutput("rst_busy",     busy,     1'b0);
        checkOutput("rst_done",     done,     1'b0);
        checkOutput("rst_sel",      sel,      8'h00);
        checkOutput("rst_response", response, 1'b0);
        checkOutput("rst_stable",   stable,   1'b0);
        checkOutput("rst_ones",     ones_cnt, 3'd0);
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      if (done) begin
        seen = 1;
        checkOutput("done_cycle", n, 49);
        checkOutput("sel_lit",    sel, ch);
        checkOutput("resp_lit",   response, exp_resp);
        checkOutput("stable_lit", stable, exp_stab);
        checkOutput("ones_lit",   ones_cnt, exp_ones);
      end
    end
    if (!seen) checkOutput("done_timeout", 1'b0, 1'b1);
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    challenge = '0;
    arb_out   = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_ones", ones_cnt, 3'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    applyStimulus(8'hA5, 7'b1111111, -1, 0, 1'b1, 1'b1, 3'd7);
    applyStimulus(8'h3C, 7'b0000000, -1, 0, 1'b0, 1'b1, 3'd0);
    applyStimulus(8'h81, 7'b0001111, -1, 0, 1'b1, 1'b0, 3'd4);
    applyStimulus(8'h7E, 7'b0000111, -1, 0, 1'b0, 1'b0, 3'd3);
    applyStimulus(8'h5A, 7'b1010101, -1, 1, 1'b1, 1'b0, 3'd4);
    applyStimulus(8'hC3, 7'b0110010, -1, 0, 1'b0, 1'b0, 3'd3);
    applyStimulus(8'h99, 7'b1111111, 20, 0, 1'b1, 1'b1, 3'd7);
    repeat (3) @(negedge clk);
    applyStimulus(8'h11, 7'b1111111, -1, 0, 1'b1, 1'b1, 3'd7);
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/puf_eval_ctrl.md
# puf_eval_ctrl

Evaluation controller sitting directly upstream of the demux race chain and downstream of its arbiter. It latches a challenge, drives the per-stage select lines and the launch pulse into the chain, samples the arbiter result after a settle window, and repeats the evaluation NEVAL times. It then reports a majority-voted response bit plus a stability flag.

## Interface
- CHAL_W, 8: challenge width; one select bit per demux stage.
- NEVAL, 7: evaluations per challenge; must be odd, ≥1.
- SETTLE, 4: cycles between launch and sample; ≥3, which covers the 2-flop synchronizer.

- clk  in  1  single clock; all state is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request an evaluation; honoured only in IDLE.
- challenge  in  CHAL_W  challenge bits, latched on an accepted start.
- launch  out  1  race launch pulse into the chain's i input.
- sel  out  CHAL_W  per-stage isel lines; equals the latched challenge.
- arb_out  in  1  arbiter result, asynchronous to clk.
- busy  out  1  high from the cycle after an accepted start through the DONE cycle.
- done  out  1  one-cycle pulse; response, stable and ones_cnt are valid.
- response  out  1  majority result; held until the next done.
- stable  out  1  1 when all NEVAL samples agree; held with response.
- ones_cnt  out  $clog2(NEVAL+1)  count of samples equal to 1; held with response.

## Operation
- Reset values: launch=0, sel=0, busy=0, done=0, response=0, stable=0, ones_cnt=0; FSM in IDLE; counters and synchronizer cleared.
- FSM states: IDLE, LAUNCH, SETTLE, SAMPLE, REST, DONE.
- IDLE: on start=1, latch challenge into sel, clear the eval and ones counters, go to LAUNCH. start=0 stays in IDLE.
- LAUNCH: launch=1 for exactly one cycle, then go to SETTLE.
- SETTLE: launch=0; hold for SETTLE cycles using the settle counter, then go to SAMPLE.
- SAMPLE: register the synchronized arb_out, increment ones_cnt if it is 1, increment the eval counter.
  - If this was evaluation NEVAL, go to DONE.
  - Otherwise go to REST.
- REST: one recovery cycle with launch=0, then go to LAUNCH.
- DONE: done=1; response = (ones_cnt > NEVAL/2); stable = (ones_cnt==0 or ones_cnt==NEVAL). Go to IDLE.
- start while busy is ignored; it is not queued.
- start in the DONE cycle is ignored. start in the following IDLE cycle is accepted.
- sel is stable for the whole evaluation and keeps its value in IDLE until the next accepted start.
- arb_out passes through a 2-flop synchronizer; only the synchronized value is used.
- Counter widths:
  - eval and ones counters: $clog2(NEVAL+1) bits, no wrap possible.
  - settle counter: $clog2(SETTLE+1) bits.
- Reset mid-operation (any state): return immediately to reset values; no done is emitted; a partial count is discarded.

## Timing
- Cycle 0 is the cycle start is sampled high in IDLE.
- Evaluation k (0-based) launches in cycle 1+k·(SETTLE+3).
- SAMPLE of evaluation k occurs in cycle 1+k·(SETTLE+3)+SETTLE+1.
- done is high in cycle NEVAL·(SETTLE+3); with defaults that is cycle 49.
- busy rises in cycle 1 and falls after the DONE cycle.
- Minimum spacing between accepted starts: NEVAL·(SETTLE+3)+1 cycles.
- All outputs are registered.

## Structure
- Package puf_pkg holds:
  - the state enum (IDLE, LAUNCH, SETTLE, SAMPLE, REST, DONE);
  - default constants PUF_CHAL_W=8, PUF_NEVAL=7, PUF_SETTLE=4.
- Sub-module sync2: 2-flop synchronizer with async active-high reset to 0, instanced on arb_out.
- Elaboration check: NEVAL odd, SETTLE≥3.

## Test plan
- Reset, then start with challenge=8'hA5 and arb_out held at 1 → sel=8'hA5; launch pulses in cycles 1, 8, …, 43; done in cycle 49 with response=1, stable=1, ones_cnt=7.
- arb_out held at 0 → done with response=0, stable=1, ones_cnt=0.
- arb_out driven 1 for evals 0–3 and 0 for evals 4–6, changed in each REST window → response=1, stable=0, ones_cnt=4. Repeat with 3 ones → response=0, ones_cnt=3.
- start pulsed in cycles 5 and 49 → both ignored; busy unaffected. start in cycle 50 → accepted; second launch sequence begins in cycle 51.
- Assert rst in cycle 20 of an evaluation → all outputs 0 on the same edge, no done pulse. The next start completes a full 49-cycle evaluation normally.
